// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM block: counting modes, count
// direction and the cfg_addr slot that selects the period register.
package pwm_pkg;

  typedef enum logic {
    PWM_MODE_EDGE   = 1'b0,
    PWM_MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    PWM_DIR_UP   = 1'b0,
    PWM_DIR_DOWN = 1'b1
  } pwm_dir_e;

  localparam int unsigned PWM_ADDR_PERIOD = 0;

endpackage

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: compares the shared counter with this channel's active
// duty, applies output polarity and registers the result.
module pwm_ch_cmp #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic             pol,
  output logic             pwm
);

  logic raw;

  assign raw = (cnt < duty);

  // Stage boundary: counter value -> registered output, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en ? (raw ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with shared edge/center-aligned counter and
// shadow/active config. Optional period_pulse output: PWM_PERIOD_PULSE_EN.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int               CH_NUM     = 4,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] PERIOD_RST = 16'd25000,
  parameter logic [CNT_W-1:0] DUTY_RST   = 16'd12500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        mode,
  input  logic [CH_NUM-1:0]           pol,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(CH_NUM+1)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]            cfg_data,
`ifdef PWM_PERIOD_PULSE_EN
  output logic                        period_pulse,
`endif
  output logic [CH_NUM-1:0]           pwm
);

  localparam int ADDR_W = $clog2(CH_NUM+1);

  logic [CNT_W-1:0]             cnt, cnt_nxt;
  pwm_dir_e                     dir, dir_nxt;
  logic [CNT_W-1:0]             per_shd, per_shd_nxt;
  logic [CNT_W-1:0]             per_act, per_act_nxt;
  logic [CH_NUM-1:0][CNT_W-1:0] duty_shd, duty_shd_nxt;
  logic [CH_NUM-1:0][CNT_W-1:0] duty_act, duty_act_nxt;
  pwm_mode_e                    mode_act, mode_act_nxt;
  logic                         cfg_wr;
  logic                         bnd;
  logic                         copy;

  // Shadow writes; out-of-range addresses fall through untouched.
  always_comb begin
    cfg_wr       = cfg_valid && cfg_ready && (cfg_addr <= ADDR_W'(CH_NUM));
    per_shd_nxt  = per_shd;
    duty_shd_nxt = duty_shd;
    if (cfg_wr && (cfg_addr == ADDR_W'(PWM_ADDR_PERIOD))) begin
      per_shd_nxt = cfg_data;
    end
    for (int k = 0; k < CH_NUM; k++) begin
      if (cfg_wr && (cfg_addr == ADDR_W'(k + 1))) begin
        duty_shd_nxt[k] = cfg_data;
      end
    end
  end

  always_comb begin
    if (mode_act == PWM_MODE_EDGE) begin
      bnd = (cnt >= per_act);
    end else begin
      bnd = (per_act == '0) || ((dir == PWM_DIR_DOWN) && (cnt == '0));
    end
  end

  // Active copy follows the shadow every idle cycle and on each boundary;
  // using the _nxt shadow bypasses a write that lands on the boundary.
  always_comb begin
    copy         = !en || bnd;
    per_act_nxt  = copy ? per_shd_nxt  : per_act;
    duty_act_nxt = copy ? duty_shd_nxt : duty_act;
    mode_act_nxt = copy ? pwm_mode_e'(mode) : mode_act;
  end

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (!en) begin
      cnt_nxt = '0;
      dir_nxt = PWM_DIR_UP;
    end else if (bnd) begin
      // Center boundary sits on the down-count 0, so resume at 1 to avoid
      // repeating 0; edge boundary sits on the top and wraps to 0.
      dir_nxt = PWM_DIR_UP;
      cnt_nxt = ((mode_act == PWM_MODE_CENTER) && (per_shd_nxt != '0))
              ? CNT_W'(1) : '0;
    end else if (mode_act == PWM_MODE_EDGE) begin
      cnt_nxt = cnt + CNT_W'(1);
    end else if (dir == PWM_DIR_UP) begin
      if (cnt >= per_act) begin
        dir_nxt = PWM_DIR_DOWN;
        cnt_nxt = cnt - CNT_W'(1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else begin
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // Stage boundary: counter and configuration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dir       <= PWM_DIR_UP;
      per_shd   <= PERIOD_RST;
      per_act   <= PERIOD_RST;
      duty_shd  <= {CH_NUM{DUTY_RST}};
      duty_act  <= {CH_NUM{DUTY_RST}};
      mode_act  <= PWM_MODE_EDGE;
      cfg_ready <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      dir       <= dir_nxt;
      per_shd   <= per_shd_nxt;
      per_act   <= per_act_nxt;
      duty_shd  <= duty_shd_nxt;
      duty_act  <= duty_act_nxt;
      mode_act  <= mode_act_nxt;
      cfg_ready <= 1'b1;
    end
  end

`ifdef PWM_PERIOD_PULSE_EN
  logic bnd_nxt;

  // Predict next cycle's boundary so the pulse coincides with it.
  always_comb begin
    if (mode_act_nxt == PWM_MODE_EDGE) begin
      bnd_nxt = (cnt_nxt >= per_act_nxt);
    end else begin
      bnd_nxt = (per_act_nxt == '0) ||
                ((dir_nxt == PWM_DIR_DOWN) && (cnt_nxt == '0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_pulse <= 1'b0;
    end else begin
      period_pulse <= en && bnd_nxt;
    end
  end
`endif

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pwm_ch_cmp #(
      .CNT_W (CNT_W)
    ) u_cmp (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .cnt   (cnt),
      .duty  (duty_act[i]),
      .pol   (pol[i]),
      .pwm   (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios plus random config traffic,
// each cycle compared with a phase-based behavioural model.
module tb_pwm_multi_ch;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int AW = $clog2(CH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          mode;
  logic [CH-1:0] pol;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic [CH-1:0] pwm;
`ifdef PWM_PERIOD_PULSE_EN
  logic          period_pulse;
`endif

  always #5 clk = ~clk;

  pwm_multi_ch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .pol          (pol),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
`ifdef PWM_PERIOD_PULSE_EN
    .period_pulse (period_pulse),
`endif
    .pwm          (pwm)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within a period as a phase index.
  // Edge: phase 0..P, count = phase.  Center: phase 0..2P, count is the
  // triangle min(phase, 2P-phase); phase 2P is the down-count 0.
  int            m_phase;
  int            m_per_act, m_per_shd;
  int            m_duty_act[CH], m_duty_shd[CH];
  bit            m_mode;
  logic [CH-1:0] m_pwm;
  logic          m_ready;
  logic          m_pulse;

  function automatic int m_cnt();
    return (m_phase <= m_per_act) ? m_phase : 2 * m_per_act - m_phase;
  endfunction

  function automatic bit m_bnd();
    if (m_mode) return (m_per_act == 0) || (m_phase == 2 * m_per_act);
    return m_phase == m_per_act;
  endfunction

  task automatic model_reset();
    m_phase   = 0;
    m_per_act = 25000;
    m_per_shd = 25000;
    for (int i = 0; i < CH; i++) begin
      m_duty_act[i] = 12500;
      m_duty_shd[i] = 12500;
    end
    m_mode  = 1'b0;
    m_pwm   = '0;
    m_ready = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit en_s, input bit mode_s,
                            input logic [CH-1:0] pol_s, input bit v,
                            input int addr, input int data);
    int c;
    bit b;
    int nper;
    int nduty[CH];
    c = m_cnt();
    b = m_bnd();
    for (int i = 0; i < CH; i++)
      m_pwm[i] = en_s ? ((c < m_duty_act[i]) ^ pol_s[i]) : pol_s[i];
    nper  = m_per_shd;
    nduty = m_duty_shd;
    if (v && m_ready && addr <= CH) begin
      if (addr == 0) nper = data;
      else nduty[addr-1] = data;
    end
    if (!en_s) m_phase = 0;
    else if (b) m_phase = (m_mode && nper != 0) ? 1 : 0;
    else m_phase = m_phase + 1;
    if (!en_s || b) begin
      m_per_act  = nper;
      m_duty_act = nduty;
      m_mode     = mode_s;
    end
    m_per_shd  = nper;
    m_duty_shd = nduty;
    m_ready    = 1'b1;
    m_pulse    = en_s && m_bnd();
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(en, mode, pol, cfg_valid, int'(cfg_addr), int'(cfg_data));
    #1;
    check("pwm", 32'(pwm), 32'(m_pwm));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
`ifdef PWM_PERIOD_PULSE_EN
    check("period_pulse", 32'(period_pulse), 32'(m_pulse));
`endif
  endtask

  task automatic write(input int addr, input int data);
    cfg_valid = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_data  = W'(data);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_bnd(input int lim);
    int n = 0;
    while (!m_bnd() && n < lim) begin
      step();
      n++;
    end
    check("boundary_reached", 32'(m_bnd()), 32'd1);
  endtask

  initial begin
    int ones;
    int exp_ones;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; pol = '0;
    cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();

    // Reset state
    #12;
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Default waveform: 12500 high / 12501 low over 25001 cycles
    ones = 0;
    for (int k = 0; k < 25001; k++) begin
      step();
      ones += int'(pwm[0]);
    end
    check("dflt_high", 32'(ones), 32'd12500);
    check("dflt_low", 32'(25001 - ones), 32'd12501);

    // Mid-period period/duty change waits for the boundary
    repeat (100) step();
    write(0, 9);
    write(1, 3);
    wait_bnd(30000);
    step();
    ones = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      ones += int'(pwm[0]);
    end
    check("p9_d3_high", 32'(ones), 32'd3);

    // Center mode, period 4, duty 2
    mode = 1'b1;
    write(0, 4);
    write(1, 2);
    wait_bnd(20);
    step();
    repeat (8) step();
    exp_ones = 0;
    for (int k = 0; k < 8; k++)
      exp_ones += (((k <= 4) ? k : 8 - k) < 2) ? 1 : 0;
    ones = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      ones += int'(pwm[0]);
    end
    check("center_high", 32'(ones), 32'(exp_ones));

    // Duty 0 / duty above period, polarity, out-of-range address
    mode = 1'b0;
    write(0, 9);
    write(2, 0);
    write(3, 20);
    write(CH + 1, 7);
    wait_bnd(20);
    repeat (12) step();
    check("duty0_low", 32'(pwm[1]), 32'd0);
    check("duty20_high", 32'(pwm[2]), 32'd1);
    pol = 4'b0110;
    repeat (12) step();
    check("duty0_inv", 32'(pwm[1]), 32'd1);
    check("duty20_inv", 32'(pwm[2]), 32'd0);
    check("badaddr_ch0", 32'(m_duty_shd[0]), 32'd2);

    // Write landing on the boundary cycle is applied immediately
    pol = '0;
    write(2, 3);
    wait_bnd(20);
    wait_bnd(20);
    write(2, 0);
    step();
    check("bnd_bypass", 32'(pwm[1]), 32'd0);

    // Asynchronous reset mid-period
    repeat (4) step();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'd0);
    check("async_rst_ready", 32'(cfg_ready), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (6) step();
    check("post_rst_dflt", 32'(pwm), 32'hF);

    // en dropped mid-count: output follows pol, count restarts
    write(0, 9);
    repeat (15) step();
    pol = 4'b1010;
    en  = 1'b0;
    repeat (3) step();
    check("en_low_pol", 32'(pwm), 32'hA);
    en = 1'b1;
    repeat (5) step();

    // Randomised config / control traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_valid = 1'b1;
        cfg_addr  = AW'($urandom_range(0, 7));
        cfg_data  = (cfg_addr == '0) ? W'($urandom_range(0, 12))
                                     : W'($urandom_range(0, 14));
      end else begin
        cfg_valid = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) pol = CH'($urandom);
      if ($urandom_range(0, 39) == 0) mode = 1'($urandom);
      if (en && $urandom_range(0, 99) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      step();
    end
    cfg_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
